// File: rtl/enter_parking_lot_pkg.sv
// Shared parking-lot definitions used by both the entry and the exit side.
//   NUM_SPOTS / SPOT_W : lot size and park-number width
//   park_state_e       : entry controller state encoding
//   is_onehot()        : true when exactly one bit of a spot vector is set
package enter_parking_lot_pkg;

  localparam int NUM_SPOTS = 8;
  localparam int SPOT_W    = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } park_state_e;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  function automatic logic is_onehot(input logic [NUM_SPOTS-1:0] v);
    return (v != '0) && ((v & (v - NUM_SPOTS'(1))) == '0);
  endfunction

endpackage

// File: rtl/lowest_free_spot.sv
// Combinational priority encoder: finds the lowest-numbered free spot.
//   occ      in  : occupancy map, bit i set = spot i taken
//   idx      out : index of the lowest zero bit (0 when none is free)
//   any_free out : at least one spot is free
module lowest_free_spot
  import enter_parking_lot_pkg::*;
(
  input  logic [NUM_SPOTS-1:0] occ,
  output logic [SPOT_W-1:0]    idx,
  output logic                 any_free
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        idx      = SPOT_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enter_parking_lot.sv
// Entry-side parking controller. Tracks occupied spots, hands the lowest
// free spot to the entry gate on each arrival and holds it until the gate
// acknowledges, and frees spots reported by the exit side.
//   clk, rst_n    : clock, asynchronous active-low reset
//   car_arrived   : one-cycle arrival request
//   gate_ack      : entry gate consumed the grant
//   car_exited    : one-cycle exit event, spot given by exit_location
//   exit_location : one-hot spot being vacated
//   park_number   : granted spot, valid while grant_valid
//   grant_valid   : grant pending acknowledgement
//   reject        : one-cycle pulse, arrival refused (lot full)
//   lot_full      : all spots occupied
//   free_count    : number of free spots
//   occupancy     : registered occupancy map
module enter_parking_lot
  import enter_parking_lot_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 car_arrived,
  input  logic                 gate_ack,
  input  logic                 car_exited,
  input  logic [NUM_SPOTS-1:0] exit_location,
  output logic [SPOT_W-1:0]    park_number,
  output logic                 grant_valid,
  output logic                 reject,
  output logic                 lot_full,
  output logic [SPOT_W:0]      free_count,
  output logic [NUM_SPOTS-1:0] occupancy
);

  park_state_e            state_q, state_d;
  logic [NUM_SPOTS-1:0]   occ_q, occ_d;
  logic [SPOT_W-1:0]      park_q, park_d;
  logic                   reject_q, reject_d;

  logic [SPOT_W-1:0]      free_idx;
  logic                   any_free;
  logic                   exit_ok;
  logic [NUM_SPOTS-1:0]   set_mask, clr_mask;
  logic [SPOT_W:0]        used_cnt;

  // Allocation always looks at the registered map, so a spot freed in the
  // same cycle is not handed out until the next arrival.
  lowest_free_spot u_lowest_free_spot (
    .occ      (occ_q),
    .idx      (free_idx),
    .any_free (any_free)
  );

  always_comb begin
    state_d  = state_q;
    park_d   = park_q;
    reject_d = 1'b0;
    set_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (car_arrived) begin
          if (any_free) begin
            park_d   = free_idx;
            set_mask = NUM_SPOTS'(1) << free_idx;
            state_d  = ST_GRANT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        // Arrivals here are dropped; the grant stays put until acked.
        if (gate_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bad exit reports (none, several, or an empty spot) are ignored.
    exit_ok  = car_exited && is_onehot(exit_location) &&
               ((exit_location & occ_q) != '0);
    clr_mask = exit_ok ? exit_location : '0;
    // The set and clear bits never overlap: one is free, the other taken.
    occ_d    = (occ_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      occ_q    <= '0;
      park_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      park_q   <= park_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    used_cnt = '0;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      used_cnt = used_cnt + {{SPOT_W{1'b0}}, occ_q[i]};
    end
  end

  assign park_number = park_q;
  assign grant_valid = (state_q == ST_GRANT);
  assign reject      = reject_q;
  assign occupancy   = occ_q;
  assign lot_full    = (occ_q == '1);
  assign free_count  = (SPOT_W + 1)'(NUM_SPOTS) - used_cnt;

endmodule

// File: tb/tb_enter_parking_lot.sv
module tb_enter_parking_lot;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       car_arrived = 1'b0;
  logic       gate_ack = 1'b0;
  logic       car_exited = 1'b0;
  logic [7:0] exit_location = 8'h00;
  logic [2:0] park_number;
  logic       grant_valid;
  logic       reject;
  logic       lot_full;
  logic [3:0] free_count;
  logic [7:0] occupancy;

  int vectors = 0;
  int miscompares = 0;

  enter_parking_lot dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .car_arrived   (car_arrived),
    .gate_ack      (gate_ack),
    .car_exited    (car_exited),
    .exit_location (exit_location),
    .park_number   (park_number),
    .grant_valid   (grant_valid),
    .reject        (reject),
    .lot_full      (lot_full),
    .free_count    (free_count),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: a list of taken spots, a pending grant, a reject flag.
  bit m_taken [8] = '{default: 1'b0};
  bit m_grant = 1'b0;
  int m_park = 0;
  bit m_reject = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_taken[i] <= 1'b0;
      m_grant  <= 1'b0;
      m_park   <= 0;
      m_reject <= 1'b0;
    end else begin
      automatic bit nt [8];
      automatic int lowest = -1;
      for (int i = 0; i < 8; i++) nt[i] = m_taken[i];
      for (int i = 7; i >= 0; i--) if (!m_taken[i]) lowest = i;
      m_reject <= 1'b0;
      if (!m_grant) begin
        if (car_arrived) begin
          if (lowest < 0) m_reject <= 1'b1;
          else begin
            nt[lowest] = 1'b1;
            m_park  <= lowest;
            m_grant <= 1'b1;
          end
        end
      end else if (gate_ack) begin
        m_grant <= 1'b0;
      end
      if (car_exited && $countones(exit_location) == 1) begin
        for (int i = 0; i < 8; i++)
          if (exit_location[i] && m_taken[i]) nt[i] = 1'b0;
      end
      for (int i = 0; i < 8; i++) m_taken[i] <= nt[i];
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: model vs DUT on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic int exp_occ = 0;
      automatic int nfree = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_taken[i]) exp_occ = exp_occ | (1 << i);
        else nfree++;
      end
      chk("m_grant_valid", grant_valid, m_grant);
      chk("m_reject", reject, m_reject);
      chk("m_occupancy", occupancy, exp_occ);
      chk("m_free_count", free_count, nfree);
      chk("m_lot_full", lot_full, nfree == 0);
      if (m_grant) chk("m_park_number", park_number, m_park);
    end
  end

  // Returns at a falling edge, after the DUT has taken one rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arrive(input int exp_park, input string name);
    car_arrived = 1'b1;
    tick();
    car_arrived = 1'b0;
    chk({name, "_grant"}, grant_valid, 1);
    chk({name, "_park"}, park_number, exp_park);
  endtask

  task automatic ack();
    gate_ack = 1'b1;
    tick();
    gate_ack = 1'b0;
  endtask

  task automatic exit_spot(input logic [7:0] loc);
    car_exited = 1'b1;
    exit_location = loc;
    tick();
    car_exited = 1'b0;
    exit_location = 8'h00;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_occ"}, occupancy, 8'h00);
    chk({name, "_park"}, park_number, 0);
    chk({name, "_grant"}, grant_valid, 0);
    chk({name, "_reject"}, reject, 0);
    chk({name, "_full"}, lot_full, 0);
    chk({name, "_free"}, free_count, 8);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Single arrival held for three cycles without ack.
    arrive(0, "first");
    chk("first_occ", occupancy, 8'h01);
    chk("first_free", free_count, 7);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_grant", grant_valid, 1);
      chk("hold_park", park_number, 0);
    end
    ack();
    chk("ack_drop", grant_valid, 0);

    // Fill the lot in order.
    for (int s = 1; s < 8; s++) begin
      arrive(s, "fill");
      ack();
    end
    chk("full_flag", lot_full, 1);
    chk("full_free", free_count, 0);
    car_arrived = 1'b1;
    tick();
    car_arrived = 1'b0;
    chk("rej_pulse", reject, 1);
    chk("rej_nogrant", grant_valid, 0);
    tick();
    chk("rej_once", reject, 0);

    // Free spot 5 in a full lot, then reuse it.
    exit_spot(8'h20);
    chk("exit5_occ", occupancy, 8'hDF);
    arrive(5, "reuse5");
    chk("reuse5_occ", occupancy, 8'hFF);
    ack();

    // Drain to 8'h07, then arrival and exit of spot 0 together.
    for (int s = 3; s < 8; s++) exit_spot(8'h01 << s);
    chk("drain_occ", occupancy, 8'h07);
    car_exited = 1'b1;
    exit_location = 8'h01;
    arrive(3, "simul");
    car_exited = 1'b0;
    exit_location = 8'h00;
    chk("simul_occ", occupancy, 8'h0E);
    chk("simul_free", free_count, 5);
    ack();

    // Malformed or stale exit reports.
    exit_spot(8'h03);
    chk("multihot_occ", occupancy, 8'h0E);
    exit_spot(8'h00);
    chk("zero_occ", occupancy, 8'h0E);
    exit_spot(8'h80);
    chk("unocc_occ", occupancy, 8'h0E);

    // Exit of the granted spot while the grant is pending.
    arrive(0, "gexit");
    exit_spot(8'h01);
    chk("gexit_grant", grant_valid, 1);
    chk("gexit_park", park_number, 0);
    chk("gexit_occ", occupancy, 8'h0E);
    ack();

    // Build 8'h3F with a pending grant, then reset asynchronously.
    arrive(0, "b0"); ack();
    arrive(4, "b4"); ack();
    arrive(5, "b5");
    chk("pre_rst_occ", occupancy, 8'h3F);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    arrive(0, "post_rst");
    ack();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      car_arrived = ($urandom_range(0, 2) == 0);
      gate_ack    = ($urandom_range(0, 2) == 0);
      car_exited  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) exit_location = 8'($urandom);
      else exit_location = 8'h01 << $urandom_range(0, 7);
      if (c == 300) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end
    car_arrived = 1'b0;
    gate_ack = 1'b0;
    car_exited = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
